// File: rtl/syscall_pkg.sv
// rtl/syscall_pkg.sv - service codes, FSM state type and byte-lane helper for syscall_engine
package syscall_pkg;

  localparam logic [31:0] SC_PRINT_INT  = 32'd1;
  localparam logic [31:0] SC_PRINT_STR  = 32'd4;
  localparam logic [31:0] SC_SBRK       = 32'd9;
  localparam logic [31:0] SC_EXIT       = 32'd10;
  localparam logic [31:0] SC_PRINT_CHAR = 32'd11;

  localparam logic [31:0] HEAP_BASE_DEFAULT = 32'h1000_0000;

  typedef enum logic [2:0] {
    IDLE,
    OUT,
    STR_RD,
    STR_WAIT,
    STR_EMIT,
    ALLOC,
    WB,
    HALT
  } state_t;

  // Memory words are big-endian: lane 0 is the most significant byte.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/heap_allocator.sv
// rtl/heap_allocator.sv - bump-pointer heap with alignment round-up; SYSCALL_HEAP_BOUNDS_EN adds limit check
module heap_allocator
  import syscall_pkg::*;
#(
  parameter logic [31:0] HEAP_BASE   = HEAP_BASE_DEFAULT,
  parameter logic [31:0] HEAP_LIMIT  = 32'h1001_0000,
  parameter int unsigned ALIGN_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_alloc,
  input  logic [31:0] i_size,
  output logic [31:0] o_old_ptr,
  output logic        o_fail
);

  if ((ALIGN_BYTES == 0) || ((ALIGN_BYTES & (ALIGN_BYTES - 1)) != 0)) begin : g_bad_align
    $error("heap_allocator: ALIGN_BYTES must be a power of two");
  end
  if (HEAP_LIMIT < HEAP_BASE) begin : g_bad_limit
    $error("heap_allocator: HEAP_LIMIT below HEAP_BASE");
  end

  logic [31:0] r_ptr;
  logic [31:0] w_next;

`ifdef SYSCALL_HEAP_BOUNDS_EN
  // Full-width arithmetic so a huge request cannot wrap past the limit check.
  localparam logic [32:0] ALIGN_M1 = 33'(ALIGN_BYTES - 1);
  logic [32:0] w_size;
  logic [33:0] w_sum;
  assign w_size = ({1'b0, i_size} + ALIGN_M1) & ~ALIGN_M1;
  assign w_sum  = {2'b00, r_ptr} + {1'b0, w_size};
  assign w_next = w_sum[31:0];
  assign o_fail = (w_sum > {2'b00, HEAP_LIMIT});
`else
  // Unchecked: everything is modulo 2^32, so 32-bit rounding gives the same pointer.
  localparam logic [31:0] ALIGN_M1 = 32'(ALIGN_BYTES - 1);
  logic [31:0] w_size;
  assign w_size = (i_size + ALIGN_M1) & ~ALIGN_M1;
  assign w_next = r_ptr + w_size;
  assign o_fail = 1'b0;
`endif

  assign o_old_ptr = r_ptr;

  // Advance the bump pointer on a successful allocate strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= HEAP_BASE;
    end else if (i_alloc && !o_fail) begin
      r_ptr <= w_next;
    end
  end

endmodule

// File: rtl/syscall_engine.sv
// rtl/syscall_engine.sv - multi-cycle syscall service unit; SYSCALL_HEAP_BOUNDS_EN enables heap bounds check
module syscall_engine
  import syscall_pkg::*;
#(
  parameter logic [31:0] HEAP_BASE   = HEAP_BASE_DEFAULT,
  parameter logic [31:0] HEAP_LIMIT  = 32'h1001_0000,
  parameter int unsigned ALIGN_BYTES = 4,
  parameter int unsigned MAX_STR_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sc_valid,
  input  logic [31:0] sc_v0,
  input  logic [31:0] sc_a0,
  output logic        sc_busy,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic        out_is_int,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        exit_req,
  output logic [31:0] heap_ptr,
  output logic        err
);

  localparam logic [31:0] MAX_LEN = 32'(MAX_STR_LEN);

  state_t      r_state;
  logic [31:0] r_a0;         // sbrk size, or the running string address
  logic [31:0] r_count;
  logic [31:0] r_word;
  logic        r_out_valid;
  logic        r_out_is_int;
  logic [31:0] r_out_data;
  logic        r_mem_req;
  logic        r_rf_we;
  logic [31:0] r_rf_wdata;
  logic        r_exit;
  logic        r_err;

  logic        w_alloc;
  logic        w_fail;
  logic [31:0] w_old_ptr;
  logic [31:0] w_addr_inc;
  logic [31:0] w_count_inc;
  logic [7:0]  w_byte_wait;
  logic [7:0]  w_byte_emit;

  assign w_alloc     = (r_state == ALLOC);
  assign w_addr_inc  = r_a0 + 32'd1;
  assign w_count_inc = r_count + 32'd1;
  assign w_byte_wait = lane_byte(mem_rdata, r_a0[1:0]);
  assign w_byte_emit = lane_byte(r_word, w_addr_inc[1:0]);

  heap_allocator #(
    .HEAP_BASE   (HEAP_BASE),
    .HEAP_LIMIT  (HEAP_LIMIT),
    .ALIGN_BYTES (ALIGN_BYTES)
  ) u_heap (
    .clk       (clk),
    .reset     (reset),
    .i_alloc   (w_alloc),
    .i_size    (r_a0),
    .o_old_ptr (w_old_ptr),
    .o_fail    (w_fail)
  );

  // Service FSM; every output except sc_busy/mem_addr is a register loaded on state entry.
  // The next string byte is looked ahead so out_valid is already correct on entering STR_EMIT;
  // a low out_valid there means the string has ended (NUL or length cap).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_a0         <= '0;
      r_count      <= '0;
      r_word       <= '0;
      r_out_valid  <= 1'b0;
      r_out_is_int <= 1'b0;
      r_out_data   <= '0;
      r_mem_req    <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_wdata   <= '0;
      r_exit       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err     <= 1'b0;
      r_rf_we   <= 1'b0;
      r_mem_req <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sc_valid) begin
            r_a0    <= sc_a0;
            r_count <= '0;
            case (sc_v0)
              SC_PRINT_INT, SC_PRINT_CHAR: begin
                r_out_valid  <= 1'b1;
                r_out_is_int <= (sc_v0 == SC_PRINT_INT);
                r_out_data   <= (sc_v0 == SC_PRINT_INT) ? sc_a0 : {24'h0, sc_a0[7:0]};
                r_state      <= OUT;
              end
              SC_PRINT_STR: begin
                r_mem_req <= 1'b1;
                r_state   <= STR_RD;
              end
              SC_SBRK: r_state <= ALLOC;
              SC_EXIT: begin
                r_exit  <= 1'b1;
                r_state <= HALT;
              end
              default: r_err <= 1'b1;
            endcase
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        STR_RD: r_state <= STR_WAIT;
        STR_WAIT: begin
          r_word       <= mem_rdata;
          r_out_is_int <= 1'b0;
          r_out_data   <= {24'h0, w_byte_wait};
          r_out_valid  <= (w_byte_wait != 8'h00) && (r_count != MAX_LEN);
          r_state      <= STR_EMIT;
        end
        STR_EMIT: begin
          if (!r_out_valid) begin
            r_state <= IDLE;
          end else if (out_ready) begin
            r_a0    <= w_addr_inc;
            r_count <= w_count_inc;
            if (w_addr_inc[1:0] == 2'd0) begin
              r_out_valid <= 1'b0;
              r_mem_req   <= 1'b1;
              r_state     <= STR_RD;
            end else begin
              r_out_data  <= {24'h0, w_byte_emit};
              r_out_valid <= (w_byte_emit != 8'h00) && (w_count_inc != MAX_LEN);
            end
          end
        end
        ALLOC: begin
          r_rf_wdata <= w_fail ? 32'h0 : w_old_ptr;
          r_err      <= w_fail;
          r_rf_we    <= 1'b1;
          r_state    <= WB;
        end
        WB:      r_state <= IDLE;
        HALT:    r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sc_busy    = sc_valid | (r_state != IDLE);
  assign mem_addr   = {r_a0[31:2], 2'b00};
  assign mem_req    = r_mem_req;
  assign out_valid  = r_out_valid;
  assign out_is_int = r_out_is_int;
  assign out_data   = r_out_data;
  assign rf_we      = r_rf_we;
  assign rf_wdata   = r_rf_wdata;
  assign exit_req   = r_exit;
  assign err        = r_err;
  assign heap_ptr   = w_old_ptr;

endmodule

// File: tb/tb_syscall_engine.sv
// tb/tb_syscall_engine.sv - scoreboard bench for syscall_engine (honours SYSCALL_HEAP_BOUNDS_EN)
module tb_syscall_engine;

  localparam logic [31:0] HB = 32'h1000_0000;
  localparam logic [31:0] HL = 32'h1001_0000;
  localparam int AL = 4;
  localparam int MS = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sc_valid = 1'b0;
  logic [31:0] sc_v0 = '0, sc_a0 = '0;
  logic        sc_busy, rf_we, mem_req, out_valid, out_is_int, exit_req, err;
  logic [31:0] rf_wdata, mem_addr, out_data, heap_ptr;
  logic [31:0] mem_rdata = '0;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  syscall_engine #(.HEAP_BASE(HB), .HEAP_LIMIT(HL), .ALIGN_BYTES(AL), .MAX_STR_LEN(MS)) dut (
    .clk(clk), .reset(reset), .sc_valid(sc_valid), .sc_v0(sc_v0), .sc_a0(sc_a0),
    .sc_busy(sc_busy), .rf_we(rf_we), .rf_wdata(rf_wdata), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_is_int(out_is_int), .out_data(out_data), .out_ready(out_ready),
    .exit_req(exit_req), .heap_ptr(heap_ptr), .err(err)
  );

  typedef struct packed { logic is_int; logic [31:0] data; } out_t;

  out_t        exp_out[$];
  logic [31:0] exp_wb[$];
  logic [31:0] exp_mem[$];
  int          exp_err = 0;
  int          n_cmp = 0, n_fail = 0;
  logic [7:0]  mem_b [0:1023];
  logic [31:0] m_heap = HB;
  logic        rdy_force = 1'b0, rdy_val = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int b;
    b = int'(a[9:2]) * 4;
    return {mem_b[b], mem_b[b+1], mem_b[b+2], mem_b[b+3]};
  endfunction

  // Reference: sbrk rounds up by division, pointer advances unless the bounded build overflows.
  task automatic model_sbrk(input logic [31:0] a0);
    longint unsigned sz, sum;
    bit fail;
    sz  = ((64'(a0) + 64'(AL - 1)) / 64'(AL)) * 64'(AL);
    sum = 64'(m_heap) + sz;
`ifdef SYSCALL_HEAP_BOUNDS_EN
    fail = (sum > 64'(HL));
`else
    fail = 1'b0;
`endif
    exp_wb.push_back(fail ? 32'h0 : m_heap);
    if (fail) exp_err++;
    else m_heap = sum[31:0];
  endtask

  // Reference: walk bytes until NUL or the cap; a word is fetched first and whenever an
  // accepted byte moves the address onto a new word boundary.
  task automatic model_string(input logic [31:0] addr);
    int n;
    logic [7:0] c;
    n = 0;
    while (n < MS) begin
      c = mem_b[(int'(addr[9:0]) + n) & 1023];
      if (c == 8'h00) break;
      exp_out.push_back({1'b0, 24'h0, c});
      n++;
    end
    exp_mem.push_back(addr & ~32'd3);
    for (int j = 1; j <= n; j++)
      if (((addr + 32'(j)) & 32'd3) == 0) exp_mem.push_back(addr + 32'(j));
  endtask

  task automatic issue(input logic [31:0] v0, input logic [31:0] a0);
    @(negedge clk);
    sc_valid = 1'b1; sc_v0 = v0; sc_a0 = a0;
    @(negedge clk);
    sc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #1;
    while (sc_busy && n < 3000) begin @(negedge clk); n++; end
    if (sc_busy) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
    end
  endtask

  // Memory: data is valid only in the cycle after mem_req; garbage otherwise.
  initial begin : mem_resp
    logic pend;
    logic [31:0] pa;
    pend = 1'b0; pa = '0;
    forever begin
      @(negedge clk);
      if (pend) mem_rdata = mem_word(pa);
      else mem_rdata = $urandom;
      pend = mem_req;
      pa = mem_addr;
    end
  end

  initial begin : ready_drv
    forever begin
      @(negedge clk);
      #1;
      out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: sees the valid/ready pair that the next rising edge will sample.
  initial begin : monitor
    logic hold, hold_int;
    logic [31:0] hold_data;
    out_t got;
    hold = 1'b0; hold_int = 1'b0; hold_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("out_valid held", {31'h0, out_valid}, 32'd1);
          chk("out_data stable", out_data, hold_data);
          chk("out_is_int stable", {31'h0, out_is_int}, {31'h0, hold_int});
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL out item: got %h expected none", out_data);
          end else begin
            got = exp_out.pop_front();
            chk("out_is_int", {31'h0, out_is_int}, {31'h0, got.is_int});
            chk("out_data", out_data, got.data);
          end
        end
        hold = out_valid && !out_ready;
        hold_data = out_data;
        hold_int = out_is_int;
        if (rf_we) begin
          if (exp_wb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL rf_we: got write %h expected none", rf_wdata);
          end else chk("rf_wdata", rf_wdata, exp_wb.pop_front());
        end
        if (err) begin
          n_cmp++;
          if (exp_err == 0) begin
            n_fail++;
            $display("FAIL err: got pulse expected none");
          end else exp_err--;
        end
        if (mem_req) begin
          if (exp_mem.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL mem_req: got %h expected none", mem_addr);
          end else chk("mem_addr", mem_addr, exp_mem.pop_front());
        end
      end
    end
  end

  initial begin : stim
    int held;
    int op;
    logic [31:0] a, c;
    int len;
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;

    // Reset values
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst sc_busy", {31'h0, sc_busy}, 32'd0);
    chk("rst rf_we", {31'h0, rf_we}, 32'd0);
    chk("rst mem_req", {31'h0, mem_req}, 32'd0);
    chk("rst out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst exit_req", {31'h0, exit_req}, 32'd0);
    chk("rst err", {31'h0, err}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst rf_wdata", rf_wdata, 32'd0);
    chk("rst heap_ptr", heap_ptr, HB);
    reset = 1'b1;

    // Print int with a stalled sink: 4 valid cycles, busy drops right after handshake
    rdy_force = 1'b1; rdy_val = 1'b0;
    exp_out.push_back({1'b1, 32'hDEADBEEF});
    @(negedge clk);
    sc_valid = 1'b1; sc_v0 = 32'd1; sc_a0 = 32'hDEADBEEF;
    #1 chk("busy same cycle", {31'h0, sc_busy}, 32'd1);
    @(negedge clk);
    sc_valid = 1'b0;
    held = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) held++;
      if (k == 3) rdy_val = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    chk("int valid cycles", 32'(held), 32'd4);
    chk("int valid dropped", {31'h0, out_valid}, 32'd0);
    chk("int busy dropped", {31'h0, sc_busy}, 32'd0);
    rdy_force = 1'b0;

    // Two allocations from a fresh heap
    model_sbrk(32'd5); issue(32'd9, 32'd5); wait_idle();
    model_sbrk(32'd8); issue(32'd9, 32'd8); wait_idle();
    chk("heap after two sbrk", heap_ptr, 32'h1000_0010);

    // Unaligned "Hi!" at 0x102
    mem_b[32'h100] = 8'h00; mem_b[32'h101] = 8'h00; mem_b[32'h102] = 8'h48; mem_b[32'h103] = 8'h69;
    mem_b[32'h104] = 8'h21; mem_b[32'h105] = 8'h00; mem_b[32'h106] = 8'h00; mem_b[32'h107] = 8'h00;
    model_string(32'h102); issue(32'd4, 32'h102); wait_idle();

    // Huge allocation: fails when bounded, wraps otherwise
    model_sbrk(32'hFFFF_FFF0); issue(32'd9, 32'hFFFF_FFF0); wait_idle();
    chk("heap after huge sbrk", heap_ptr, m_heap);

    // Length cap: 300 non-NUL bytes, only MS emitted
    for (int i = 0; i < 300; i++) mem_b[32'h201 + i] = 8'(i % 200 + 1);
    mem_b[32'h201 + 300] = 8'h00;
    model_string(32'h201); issue(32'd4, 32'h201); wait_idle();

    // Randomized services
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 5);
      a = $urandom;
      case (op)
        0: begin exp_out.push_back({1'b1, a}); issue(32'd1, a); end
        1: begin exp_out.push_back({1'b0, 24'h0, a[7:0]}); issue(32'd11, a); end
        2, 5: begin
          a = $urandom_range(0, 900);
          len = $urandom_range(0, 12);
          for (int i = 0; i < len; i++) mem_b[int'(a) + i] = 8'($urandom_range(1, 255));
          mem_b[int'(a) + len] = 8'h00;
          model_string(a); issue(32'd4, a);
        end
        3: begin
          a = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 100));
          model_sbrk(a); issue(32'd9, a);
        end
        default: begin
          c = $urandom;
          if (c == 1 || c == 4 || c == 9 || c == 10 || c == 11) c = 32'd7;
          exp_err++; issue(c, a);
        end
      endcase
      wait_idle();
      chk("heap_ptr", heap_ptr, m_heap);
    end

    // Unsupported code 7: err only
    exp_err++; issue(32'd7, 32'h1234); wait_idle();
    repeat (3) @(negedge clk);
    chk("code7 heap", heap_ptr, m_heap);
    chk("code7 out_valid", {31'h0, out_valid}, 32'd0);
    chk("code7 busy", {31'h0, sc_busy}, 32'd0);

    // Reset while a string byte is waiting in STR_EMIT
    for (int i = 0; i < 7; i++) mem_b[32'h300 + i] = 8'h41 + 8'(i);
    mem_b[32'h307] = 8'h00;
    rdy_force = 1'b1; rdy_val = 1'b0;
    exp_mem.push_back(32'h300);
    issue(32'd4, 32'h300);
    repeat (3) @(negedge clk);
    chk("pre-reset out_valid", {31'h0, out_valid}, 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("abort busy", {31'h0, sc_busy}, 32'd0);
    chk("abort out_valid", {31'h0, out_valid}, 32'd0);
    chk("abort out_data", out_data, 32'd0);
    chk("abort mem_req", {31'h0, mem_req}, 32'd0);
    chk("abort heap_ptr", heap_ptr, HB);
    exp_out.delete();
    m_heap = HB;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rdy_force = 1'b0;

    // Exit is sticky and ignores further syscalls
    issue(32'd10, 32'd0);
    repeat (2) @(negedge clk);
    chk("exit_req set", {31'h0, exit_req}, 32'd1);
    chk("halt busy", {31'h0, sc_busy}, 32'd1);
    issue(32'd1, 32'h55);
    repeat (10) @(negedge clk);
    chk("exit_req sticky", {31'h0, exit_req}, 32'd1);
    chk("halt busy held", {31'h0, sc_busy}, 32'd1);
    chk("halt no output", {31'h0, out_valid}, 32'd0);

    chk("out queue drained", 32'(exp_out.size()), 32'd0);
    chk("wb queue drained", 32'(exp_wb.size()), 32'd0);
    chk("mem queue drained", 32'(exp_mem.size()), 32'd0);
    chk("err expectations met", 32'(exp_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
